// File: rtl/dispense_scheduler_if.sv
// Signal bundle between the time matcher / configuration host and the dispense scheduler.
// The master side drives requests and configuration; the slave side returns motor and status.
interface dispense_scheduler_if #(
   parameter int NUM_CH    = 4,
   parameter int NUM_SLOTS = 3,
   parameter int CNT_W     = 5
);
   localparam int CH_W = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

   logic [NUM_SLOTS-1:0] slot_p;
   logic                 cfg_we;
   logic [CH_W-1:0]      cfg_ch;
   logic [NUM_SLOTS-1:0] cfg_mask;
   logic [CNT_W-1:0]     cfg_count;
   logic [NUM_CH-1:0]    ovr_p;
   logic                 alarm_ack;
   logic [NUM_CH-1:0]    motor;
   logic                 alarm;
   logic [NUM_CH-1:0]    empty;
   logic [NUM_CH-1:0]    missed;
   logic                 busy;

   modport master (
      output slot_p, cfg_we, cfg_ch, cfg_mask, cfg_count, ovr_p, alarm_ack,
      input  motor, alarm, empty, missed, busy
   );

   modport slave (
      input  slot_p, cfg_we, cfg_ch, cfg_mask, cfg_count, ovr_p, alarm_ack,
      output motor, alarm, empty, missed, busy
   );
endinterface

// File: rtl/dispense_scheduler.sv
// Pill dispenser scheduler: collects per-channel dose events into one-deep pending requests
// and serves them round-robin, one motor pulse at a time, each followed by an all-off gap.
module dispense_scheduler #(
   parameter int NUM_CH       = 4,
   parameter int NUM_SLOTS    = 3,
   parameter int CNT_W        = 5,
   parameter int PULSE_CYCLES = 25_000_000,
   parameter int GAP_CYCLES   = 5_000_000
) (
   input logic                 CLOCK_50,
   input logic                 resetn,
   dispense_scheduler_if.slave bus
);
   localparam int CH_W    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
   localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [CH_W:0]     NUM_CH_W = (CH_W + 1)'(NUM_CH);
   localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [NUM_CH-1:0] ONE_CH   = {{(NUM_CH - 1){1'b0}}, 1'b1};
   localparam logic [TMR_W-1:0]  PULSE_LD = TMR_W'(PULSE_CYCLES - 1);
   localparam logic [TMR_W-1:0]  GAP_LD   = TMR_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [TMR_W-1:0]  timer_r, timer_nxt_s;
   logic [CH_W-1:0]   last_r, last_nxt_s;
   logic [NUM_CH-1:0] motor_r, motor_nxt_s;
   logic              busy_r;
   logic              alarm_r, alarm_nxt_s;
   logic [NUM_CH-1:0] req_r, req_nxt_s;
   logic [NUM_CH-1:0] missed_r, missed_nxt_s;
   logic [NUM_CH-1:0] empty_r;
   logic [CNT_W-1:0]     count_r [NUM_CH];
   logic [CNT_W-1:0]     count_nxt_s [NUM_CH];
   logic [NUM_SLOTS-1:0] mask_r [NUM_CH];
   logic [NUM_SLOTS-1:0] mask_nxt_s [NUM_CH];

   logic              grant_s;
   logic [CH_W-1:0]   gnt_s;
   logic              gnt_found_s;
   logic [CH_W:0]     rr_sum_s;
   logic [CH_W:0]     rr_idx_s;
   logic              rr_hit_s;
   logic [NUM_CH-1:0] cfg_hit_s;
   logic [NUM_CH-1:0] take_s;
   logic [NUM_CH-1:0] event_s;
   logic [NUM_CH-1:0] held_s;
   logic [NUM_CH-1:0] miss_set_s;

   assign grant_s = (state_r == ST_IDLE) && (req_r != '0);

   // Round-robin pick: first pending channel searching upward from the one after the last grant.
   always_comb begin
      gnt_s       = last_r;
      gnt_found_s = 1'b0;
      rr_sum_s    = '0;
      rr_idx_s    = '0;
      rr_hit_s    = 1'b0;
      for (int k = 1; k <= NUM_CH; k++) begin
         rr_sum_s    = {1'b0, last_r} + (CH_W + 1)'(k);
         rr_idx_s    = (rr_sum_s >= NUM_CH_W) ? (rr_sum_s - NUM_CH_W) : rr_sum_s;
         rr_hit_s    = !gnt_found_s && req_r[rr_idx_s[CH_W-1:0]];
         gnt_s       = rr_hit_s ? rr_idx_s[CH_W-1:0] : gnt_s;
         gnt_found_s = gnt_found_s || rr_hit_s;
      end
   end

   // Per-channel request, missed flag, count and mask next-state.
   always_comb begin
      cfg_hit_s    = '0;
      take_s       = '0;
      event_s      = '0;
      held_s       = '0;
      miss_set_s   = '0;
      req_nxt_s    = req_r;
      missed_nxt_s = missed_r;
      count_nxt_s  = count_r;
      mask_nxt_s   = mask_r;
      for (int i = 0; i < NUM_CH; i++) begin
         cfg_hit_s[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
         take_s[i]    = grant_s && (gnt_s == CH_W'(i));
         event_s[i]   = bus.ovr_p[i] || ((bus.slot_p & mask_r[i]) != '0);
         // A grant frees the pending slot in the same cycle, so a coincident event re-arms it.
         held_s[i]    = req_r[i] && !take_s[i];
         if (event_s[i] && ((count_r[i] == '0) || held_s[i])) begin
            req_nxt_s[i]  = held_s[i];
            miss_set_s[i] = 1'b1;
         end else begin
            req_nxt_s[i]  = held_s[i] || event_s[i];
            miss_set_s[i] = 1'b0;
         end
         missed_nxt_s[i] = cfg_hit_s[i] ? 1'b0 : (missed_r[i] || miss_set_s[i]);
         if (cfg_hit_s[i]) begin
            count_nxt_s[i] = bus.cfg_count;
            mask_nxt_s[i]  = bus.cfg_mask;
         end else if (take_s[i] && (count_r[i] != '0)) begin
            count_nxt_s[i] = count_r[i] - CNT_W'(1);
            mask_nxt_s[i]  = mask_r[i];
         end else begin
            count_nxt_s[i] = count_r[i];
            mask_nxt_s[i]  = mask_r[i];
         end
      end
   end

   // Dispense FSM next-state, phase timer and motor drive.
   always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      last_nxt_s  = last_r;
      motor_nxt_s = '0;
      case (state_r)
         ST_IDLE: begin
            if (grant_s) begin
               state_nxt_s = ST_DRIVE;
               timer_nxt_s = PULSE_LD;
               last_nxt_s  = gnt_s;
               motor_nxt_s = ONE_CH << gnt_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (timer_r == '0) begin
               state_nxt_s = ST_GAP;
               timer_nxt_s = GAP_LD;
            end else begin
               timer_nxt_s = timer_r - TMR_W'(1);
               motor_nxt_s = motor_r;
            end
         end
         ST_GAP: begin
            if (timer_r == '0) begin
               state_nxt_s = ST_IDLE;
            end else begin
               timer_nxt_s = timer_r - TMR_W'(1);
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            timer_nxt_s = '0;
         end
      endcase
   end

   // Alarm: a new dose sets it, acknowledge clears it, set dominates.
   always_comb begin
      if (grant_s) begin
         alarm_nxt_s = 1'b1;
      end else if (bus.alarm_ack) begin
         alarm_nxt_s = 1'b0;
      end else begin
         alarm_nxt_s = alarm_r;
      end
   end

   // FSM state register and registered motor/busy/alarm outputs.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
         timer_r <= '0;
         last_r  <= LAST_CH;
         motor_r <= '0;
         busy_r  <= 1'b0;
         alarm_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         timer_r <= timer_nxt_s;
         last_r  <= last_nxt_s;
         motor_r <= motor_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         alarm_r <= alarm_nxt_s;
      end
   end

   // Channel bookkeeping registers; empty follows the count one cycle later.
   always_ff @(posedge CLOCK_50) begin
      if (!resetn) begin
         req_r    <= '0;
         missed_r <= '0;
         empty_r  <= '1;
         for (int i = 0; i < NUM_CH; i++) begin
            count_r[i] <= '0;
            mask_r[i]  <= '0;
         end
      end else begin
         req_r    <= req_nxt_s;
         missed_r <= missed_nxt_s;
         for (int i = 0; i < NUM_CH; i++) begin
            count_r[i] <= count_nxt_s[i];
            mask_r[i]  <= mask_nxt_s[i];
            empty_r[i] <= (count_r[i] == '0);
         end
      end
   end

   assign bus.motor  = motor_r;
   assign bus.alarm  = alarm_r;
   assign bus.empty  = empty_r;
   assign bus.missed = missed_r;
   assign bus.busy   = busy_r;
endmodule

// File: tb/tb_dispense_scheduler.sv
// Bench for dispense_scheduler: a cycle table, hand-built corner sequences and random
// stimulus, all compared against a timeline-based reference model.
module tb_dispense_scheduler;
   localparam int P = 4;
   localparam int G = 2;

   logic CLOCK_50;
   logic resetn;

   dispense_scheduler_if #(.NUM_CH(4), .NUM_SLOTS(3), .CNT_W(5)) bus ();

   dispense_scheduler #(
      .NUM_CH(4), .NUM_SLOTS(3), .CNT_W(5), .PULSE_CYCLES(P), .GAP_CYCLES(G)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .resetn  (resetn),
      .bus     (bus)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   int total = 0;
   int bad   = 0;

   // reference model: dose timeline kept as a start cycle plus the served channel
   int         m_cnt [4];
   logic [2:0] m_mask [4];
   logic [3:0] m_req, m_miss, m_empty, x_motor;
   logic       m_alarm, m_act, x_busy;
   int         m_last, m_ch, m_s, e_cnt;

   logic [3:0] prev_motor;
   int         rises [4];
   int         st_ch [$];
   int         st_t  [$];

   typedef struct {
      logic [2:0] slot;
      logic [3:0] ovr;
      logic       we;
      logic [1:0] ch;
      logic [2:0] mask;
      logic [4:0] cnt;
      logic       ack;
      logic [3:0] e_motor;
      logic       e_alarm;
      logic       e_busy;
      logic [3:0] e_missed;
      logic [3:0] e_empty;
   } vec_t;

   vec_t tbl [10];

   function automatic vec_t mk(logic [2:0] s, logic [3:0] o, logic we, logic [1:0] ch,
                               logic [2:0] m, logic [4:0] c, logic a, logic [3:0] em,
                               logic ea, logic eb, logic [3:0] ems, logic [3:0] ee);
      vec_t v;
      v.slot = s; v.ovr = o; v.we = we; v.ch = ch; v.mask = m; v.cnt = c; v.ack = a;
      v.e_motor = em; v.e_alarm = ea; v.e_busy = eb; v.e_missed = ems; v.e_empty = ee;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, e_cnt);
      end
   endtask

   task automatic model_step();
      logic [3:0] ev, nreq, nmiss;
      int         ncnt [4];
      logic       grant, found;
      int         g, c;
      e_cnt++;
      if (!resetn) begin
         for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_mask[i] = 3'b000;
         end
         m_req = 4'b0000; m_miss = 4'b0000; m_empty = 4'b1111;
         m_alarm = 1'b0; m_act = 1'b0; m_last = 3; m_ch = 0; m_s = 0;
      end else begin
         grant = (!m_act || (e_cnt - 1 - m_s >= P + G)) && (m_req != 4'b0000);
         g = 0;
         found = 1'b0;
         for (int k = 1; k <= 4; k++) begin
            c = (m_last + k) % 4;
            if (!found && m_req[c]) begin
               g = c;
               found = 1'b1;
            end
         end
         for (int i = 0; i < 4; i++) begin
            ev[i]    = bus.ovr_p[i] || ((bus.slot_p & m_mask[i]) != 3'b000);
            nreq[i]  = m_req[i] && !(grant && g == i);
            nmiss[i] = m_miss[i];
            ncnt[i]  = m_cnt[i];
            if (ev[i]) begin
               if (m_cnt[i] == 0 || nreq[i]) nmiss[i] = 1'b1;
               else nreq[i] = 1'b1;
            end
            if (grant && g == i && m_cnt[i] > 0) ncnt[i] = m_cnt[i] - 1;
            if (bus.cfg_we && int'(bus.cfg_ch) == i) begin
               ncnt[i]   = int'(bus.cfg_count);
               m_mask[i] = bus.cfg_mask;
               nmiss[i]  = 1'b0;
            end
            m_empty[i] = (m_cnt[i] == 0);
         end
         for (int i = 0; i < 4; i++) m_cnt[i] = ncnt[i];
         m_req  = nreq;
         m_miss = nmiss;
         if (grant) begin
            m_act = 1'b1; m_s = e_cnt; m_ch = g; m_last = g; m_alarm = 1'b1;
         end else if (bus.alarm_ack) begin
            m_alarm = 1'b0;
         end
      end
      x_motor = (m_act && (e_cnt - m_s) < P) ? (4'b0001 << m_ch) : 4'b0000;
      x_busy  = m_act && ((e_cnt - m_s) < P + G);
   endtask

   task automatic cyc();
      @(posedge CLOCK_50);
      model_step();
      #1;
      chk("m_motor",  32'(bus.motor),  32'(x_motor));
      chk("m_alarm",  32'(bus.alarm),  32'(m_alarm));
      chk("m_busy",   32'(bus.busy),   32'(x_busy));
      chk("m_missed", 32'(bus.missed), 32'(m_miss));
      chk("m_empty",  32'(bus.empty),  32'(m_empty));
      chk("onehot",   32'($countones(bus.motor) <= 1), 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (bus.motor[i] && !prev_motor[i]) begin
            rises[i]++;
            st_ch.push_back(i);
            st_t.push_back(e_cnt);
         end
      end
      prev_motor = bus.motor;
   endtask

   task automatic idle_in();
      bus.slot_p = 3'b000; bus.ovr_p = 4'b0000; bus.cfg_we = 1'b0;
      bus.cfg_ch = 2'd0; bus.cfg_mask = 3'b000; bus.cfg_count = 5'd0; bus.alarm_ack = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_reset();
      idle_in();
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) rises[i] = 0;
      st_ch.delete();
      st_t.delete();
   endtask

   task automatic cfg(input logic [1:0] ch, input logic [2:0] m, input logic [4:0] c);
      bus.cfg_we = 1'b1; bus.cfg_ch = ch; bus.cfg_mask = m; bus.cfg_count = c;
      cyc();
      idle_in();
   endtask

   task automatic slot(input logic [2:0] s);
      bus.slot_p = s;
      cyc();
      bus.slot_p = 3'b000;
   endtask

   initial begin
      int   n;
      logic seen;
      logic [3:0] any_m;
      resetn = 1'b1;
      prev_motor = 4'b0000;
      e_cnt = 0;
      idle_in();

      // reset values
      do_reset();
      chk("rst_motor",  32'(bus.motor),  32'd0);
      chk("rst_alarm",  32'(bus.alarm),  32'd0);
      chk("rst_busy",   32'(bus.busy),   32'd0);
      chk("rst_missed", 32'(bus.missed), 32'd0);
      chk("rst_empty",  32'(bus.empty),  32'hF);

      // single slot dose on ch1: row 1 is cycle t, observations are one cycle later
      tbl[0] = mk(3'b000, 4'b0000, 1'b1, 2'd1, 3'b001, 5'd2, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111);
      tbl[1] = mk(3'b001, 4'b0000, 1'b0, 2'd0, 3'b000, 5'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1101);
      tbl[2] = mk(3'b000, 4'b0000, 1'b0, 2'd0, 3'b000, 5'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b1101);
      tbl[3] = mk(3'b000, 4'b0000, 1'b0, 2'd0, 3'b000, 5'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b1101);
      tbl[4] = mk(3'b000, 4'b0000, 1'b0, 2'd0, 3'b000, 5'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b1101);
      tbl[5] = mk(3'b000, 4'b0000, 1'b0, 2'd0, 3'b000, 5'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b1101);
      tbl[6] = mk(3'b000, 4'b0000, 1'b0, 2'd0, 3'b000, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b1101);
      tbl[7] = mk(3'b000, 4'b0000, 1'b0, 2'd0, 3'b000, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 4'b1101);
      tbl[8] = mk(3'b000, 4'b0000, 1'b0, 2'd0, 3'b000, 5'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1101);
      tbl[9] = mk(3'b000, 4'b0000, 1'b0, 2'd0, 3'b000, 5'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1101);
      for (int r = 0; r < 10; r++) begin
         bus.slot_p = tbl[r].slot; bus.ovr_p = tbl[r].ovr; bus.cfg_we = tbl[r].we;
         bus.cfg_ch = tbl[r].ch; bus.cfg_mask = tbl[r].mask; bus.cfg_count = tbl[r].cnt;
         bus.alarm_ack = tbl[r].ack;
         cyc();
         chk("t_motor",  32'(bus.motor),  32'(tbl[r].e_motor));
         chk("t_alarm",  32'(bus.alarm),  32'(tbl[r].e_alarm));
         chk("t_busy",   32'(bus.busy),   32'(tbl[r].e_busy));
         chk("t_missed", 32'(bus.missed), 32'(tbl[r].e_missed));
         chk("t_empty",  32'(bus.empty),  32'(tbl[r].e_empty));
         idle_in();
      end

      // round-robin order over four pending channels
      do_reset();
      for (int c = 0; c < 4; c++) cfg(2'(c), 3'b010, 5'd3);
      slot(3'b010);
      run(40);
      chk("rr_npulse", 32'(st_ch.size()), 32'd4);
      for (int k = 0; k < 4 && k < st_ch.size(); k++) begin
         chk("rr_order", 32'(st_ch[k]), 32'(k));
         if (k > 0) chk("rr_spacing", 32'((st_t[k] - st_t[k-1]) >= P + G), 32'd1);
      end
      chk("rr_missed", 32'(bus.missed), 32'd0);

      // ch2 with a single pill hit by two slot events
      do_reset();
      cfg(2'd2, 3'b001, 5'd1);
      slot(3'b001);
      run(19);
      slot(3'b001);
      run(2);
      chk("one_pulses", 32'(rises[2]), 32'd1);
      chk("one_empty2", 32'(bus.empty[2]), 32'd1);
      chk("one_missed2", 32'(bus.missed[2]), 32'd1);

      // second override while ch0 is already pending
      do_reset();
      cfg(2'd3, 3'b100, 5'd2);
      cfg(2'd0, 3'b000, 5'd2);
      slot(3'b100);
      cyc();
      chk("pend_ch3", 32'(bus.motor), 32'h8);
      bus.ovr_p = 4'b0001;
      cyc();
      chk("pend_first", 32'(bus.missed), 32'd0);
      cyc();
      bus.ovr_p = 4'b0000;
      chk("pend_second", 32'(bus.missed), 32'h1);
      run(25);
      chk("pend_pulses", 32'(rises[0]), 32'd1);

      // reset during the second DRIVE cycle
      do_reset();
      cfg(2'd1, 3'b001, 5'd2);
      slot(3'b001);
      run(3);
      chk("mid_drive", 32'(bus.motor), 32'h2);
      resetn = 1'b0;
      cyc();
      resetn = 1'b1;
      chk("mid_motor",  32'(bus.motor),  32'd0);
      chk("mid_alarm",  32'(bus.alarm),  32'd0);
      chk("mid_busy",   32'(bus.busy),   32'd0);
      chk("mid_missed", 32'(bus.missed), 32'd0);
      chk("mid_empty",  32'(bus.empty),  32'hF);
      any_m = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         cyc();
         any_m = any_m | bus.motor;
      end
      chk("mid_nopulse", 32'(any_m), 32'd0);

      // acknowledge coincident with a new DRIVE entry
      do_reset();
      cfg(2'd0, 3'b001, 5'd3);
      cfg(2'd1, 3'b001, 5'd3);
      slot(3'b001);
      n = 0;
      seen = 1'b0;
      while (!(seen && !bus.busy) && n < 30) begin
         cyc();
         if (bus.busy) seen = 1'b1;
         n++;
      end
      chk("ack_wait", 32'(n < 30), 32'd1);
      bus.alarm_ack = 1'b1;
      cyc();
      chk("ack_hold", 32'(bus.alarm), 32'd1);
      chk("ack_grant", 32'(bus.motor), 32'h2);
      cyc();
      chk("ack_clear", 32'(bus.alarm), 32'd0);
      idle_in();

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         bus.slot_p    = 3'b000;
         bus.ovr_p     = 4'b0000;
         for (int b = 0; b < 3; b++) bus.slot_p[b] = ($urandom_range(11, 0) == 0);
         for (int b = 0; b < 4; b++) bus.ovr_p[b] = ($urandom_range(19, 0) == 0);
         bus.cfg_we    = ($urandom_range(9, 0) == 0);
         bus.cfg_ch    = 2'($urandom_range(3, 0));
         bus.cfg_mask  = 3'($urandom_range(7, 0));
         bus.cfg_count = 5'($urandom_range(3, 0));
         bus.alarm_ack = ($urandom_range(5, 0) == 0);
         resetn        = ($urandom_range(299, 0) != 0);
         cyc();
      end
      resetn = 1'b1;
      idle_in();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
